reg_file_2r1w: RTL and testbench

Parametrised register file: one write port and two synchronous read ports, with a write-first bypass, optional hardwired-zero register 0, and a sequenced bulk-clear engine. Generalised successor to the 16 x 32 decoder/register/mux register file. Sits in the datapath between the instruction decode stage (addresses) and the ALU operand latches (read data).

---
 rtl/reg_file_pkg.sv | 24 ++
 rtl/onehot_decoder.sv | 25 ++
 rtl/reg_file_2r1w.sv | 152 +++++++++++++++
 tb/tb_reg_file_2r1w.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_pkg
// Brief    : Shared types and constants for the 2-read/1-write register file.
// Revision : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 16;

    // Sweep controller states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Address width for a given depth; never narrower than one bit
    function automatic int calc_aw(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module   : onehot_decoder
// Brief    : AW-bit address plus enable to DEPTH-bit one-hot strobe. Addresses
//            at or beyond DEPTH match no output bit and give all zeros.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_decoder
    import reg_file_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = calc_aw(DEFAULT_DEPTH)
) (
    input  logic [AW-1:0]    i_addr,
    input  logic             i_en,
    output logic [DEPTH-1:0] o_onehot
);

    // One comparator per output line; out-of-range codes have no line
    for (genvar g = 0; g < DEPTH; g++) begin : g_line
        assign o_onehot[g] = i_en && (i_addr == AW'(g));
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_2r1w
// Brief    : Parametrised register file, one write port and two registered
//            read ports with write-first bypass, optional hardwired-zero
//            register 0 and a one-entry-per-cycle bulk-clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ZERO_REG = 0,
    localparam int AW      = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic             rd_valid,
    input  logic             clr_req,
    output logic             busy
);

    localparam logic [AW:0]   c_depth    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);
    localparam bit            c_zero_reg = (ZERO_REG != 0);

    state_t             r_state;
    state_t             w_state_next;
    logic [AW-1:0]      r_idx;
    logic               w_idle;
    logic               w_clr_en;
    logic               w_wr_en;
    logic [DEPTH-1:0]   w_wr_stb;
    logic [DEPTH-1:0]   w_clr_stb;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [WIDTH-1:0]   w_ra_next;
    logic [WIDTH-1:0]   w_rb_next;
    logic [WIDTH-1:0]   r_ra_data;
    logic [WIDTH-1:0]   r_rb_data;
    logic               r_rd_valid;

    // Writes only land while idle; register 0 swallows writes when hardwired
    assign w_wr_en = we && w_idle && !(c_zero_reg && (waddr == '0));

    onehot_decoder #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_wr_dec (
        .i_addr   (waddr),
        .i_en     (w_wr_en),
        .o_onehot (w_wr_stb)
    );

    onehot_decoder #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_dec (
        .i_addr   (r_idx),
        .i_en     (w_clr_en),
        .o_onehot (w_clr_stb)
    );

    // State register of the clear sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next state: start on clr_req, finish on the edge that clears the last entry
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (clr_req) w_state_next = CLEAR;
            CLEAR:   if (r_idx == c_last_idx) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State decode: busy comes straight from the state flop
    always_comb begin
        w_idle   = (r_state == IDLE);
        w_clr_en = (r_state == CLEAR);
        busy     = (r_state == CLEAR);
    end

    // Sweep index walks 0..DEPTH-1 while clearing and parks at 0 otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_idx <= '0;
        else if (!w_clr_en || r_idx == c_last_idx) r_idx <= '0;
        else                                     r_idx <= r_idx + AW'(1);
    end

    // Storage: clear strobe and write strobe never overlap (different states)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_clr_stb[i])     r_mem[i] <= '0;
                else if (w_wr_stb[i]) r_mem[i] <= wdata;
            end
        end
    end

    // Port A source: range/zero-reg gating first, then same-edge write bypass
    always_comb begin
        w_ra_next = '0;
        if (({1'b0, ra_addr} < c_depth) && !(c_zero_reg && (ra_addr == '0))) begin
            if (w_wr_en && (waddr == ra_addr)) w_ra_next = wdata;
            else                               w_ra_next = r_mem[ra_addr];
        end
    end

    // Port B source: same selection as port A, independent bypass
    always_comb begin
        w_rb_next = '0;
        if (({1'b0, rb_addr} < c_depth) && !(c_zero_reg && (rb_addr == '0))) begin
            if (w_wr_en && (waddr == rb_addr)) w_rb_next = wdata;
            else                               w_rb_next = r_mem[rb_addr];
        end
    end

    // Read data registers: update on accepted read, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra_data  <= '0;
            r_rb_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_idle && re) begin
            r_ra_data  <= w_ra_next;
            r_rb_data  <= w_rb_next;
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign ra_data  = r_ra_data;
    assign rb_data  = r_rb_data;
    assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_2r1w
// Brief    : Bench for reg_file_2r1w. Three instances share one stimulus
//            stream: default, ZERO_REG=1, and DEPTH=12.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_2r1w;

    localparam int N = 3;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [3:0]  ra_addr;
    logic [3:0]  rb_addr;
    logic        clr_req;

    logic [31:0] ra_d [N];
    logic [31:0] rb_d [N];
    logic        vld  [N];
    logic        bsy  [N];

    // Reference model state
    logic [31:0] m_mem [N][16];
    int          m_left [N];
    logic [31:0] m_ra [N];
    logic [31:0] m_rb [N];
    logic        m_vld [N];

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_file_2r1w u_dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_d[0]), .rb_data(rb_d[0]), .rd_valid(vld[0]),
        .clr_req(clr_req), .busy(bsy[0])
    );

    reg_file_2r1w #(.ZERO_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_d[1]), .rb_data(rb_d[1]), .rd_valid(vld[1]),
        .clr_req(clr_req), .busy(bsy[1])
    );

    reg_file_2r1w #(.DEPTH(12)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_d[2]), .rb_data(rb_d[2]), .rd_valid(vld[2]),
        .clr_req(clr_req), .busy(bsy[2])
    );

    function automatic int dep(input int i);
        return (i == 2) ? 12 : 16;
    endfunction

    function automatic bit zr(input int i);
        return (i == 1);
    endfunction

    function automatic logic [31:0] m_read(input int i, input logic [3:0] a);
        if (int'(a) >= dep(i) || (zr(i) && a == 4'd0)) return 32'h0;
        return m_mem[i][a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            for (int a = 0; a < 16; a++) m_mem[i][a] = 32'h0;
            m_left[i] = 0;
            m_ra[i]   = 32'h0;
            m_rb[i]   = 32'h0;
            m_vld[i]  = 1'b0;
        end
    endtask

    // One clock edge of behaviour: a pending sweep swallows the cycle,
    // otherwise write first, then read the updated contents.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            if (m_left[i] > 0) begin
                m_mem[i][dep(i) - m_left[i]] = 32'h0;
                m_left[i] = m_left[i] - 1;
                m_vld[i]  = 1'b0;
            end else begin
                if (we && int'(waddr) < dep(i) && !(zr(i) && waddr == 4'd0))
                    m_mem[i][waddr] = wdata;
                if (re) begin
                    m_ra[i]  = m_read(i, ra_addr);
                    m_rb[i]  = m_read(i, rb_addr);
                    m_vld[i] = 1'b1;
                end else begin
                    m_vld[i] = 1'b0;
                end
                if (clr_req) m_left[i] = dep(i);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; re = 1'b0; clr_req = 1'b0;
        waddr = 4'd0; wdata = 32'h0; ra_addr = 4'd0; rb_addr = 4'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #3;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({ra_d[i], rb_d[i], vld[i], bsy[i]} !== 66'h0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d got ra=%h rb=%h vld=%b busy=%b exp all 0",
                         i, ra_d[i], rb_d[i], vld[i], bsy[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        re = 1'b1; ra_addr = 4'd0; rb_addr = 4'd15;
        tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({vld[i], ra_d[i], rb_d[i]} !== {1'b1, 32'h0, 32'h0}) begin
                failures++;
                $display("FAIL reset_read dut%0d got vld=%b ra=%h rb=%h exp vld=1 ra=0 rb=0",
                         i, vld[i], ra_d[i], rb_d[i]);
            end
        end
    endtask

    task automatic test_write_read();
        idle_inputs();
        we = 1'b1; waddr = 4'd5; wdata = 32'hDEADBEEF;
        tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (vld[i] !== 1'b0) begin
                failures++;
                $display("FAIL write_no_valid dut%0d got vld=%b exp 0", i, vld[i]);
            end
        end
        we = 1'b0; re = 1'b1; ra_addr = 4'd5; rb_addr = 4'd5;
        tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({vld[i], ra_d[i], rb_d[i]} !== {1'b1, 32'hDEADBEEF, 32'hDEADBEEF}) begin
                failures++;
                $display("FAIL write_read dut%0d got vld=%b ra=%h rb=%h exp 1 deadbeef deadbeef",
                         i, vld[i], ra_d[i], rb_d[i]);
            end
        end
        re = 1'b0; ra_addr = 4'd0; rb_addr = 4'd0;
        tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({vld[i], ra_d[i], rb_d[i]} !== {1'b0, 32'hDEADBEEF, 32'hDEADBEEF}) begin
                failures++;
                $display("FAIL read_hold dut%0d got vld=%b ra=%h rb=%h exp 0 deadbeef deadbeef",
                         i, vld[i], ra_d[i], rb_d[i]);
            end
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        we = 1'b1; waddr = 4'd4; wdata = 32'hA5A5A5A5;
        tick();
        we = 1'b1; waddr = 4'd3; wdata = 32'h12345678;
        re = 1'b1; ra_addr = 4'd3; rb_addr = 4'd4;
        tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({vld[i], ra_d[i], rb_d[i]} !== {1'b1, 32'h12345678, 32'hA5A5A5A5}) begin
                failures++;
                $display("FAIL bypass dut%0d got vld=%b ra=%h rb=%h exp 1 12345678 a5a5a5a5",
                         i, vld[i], ra_d[i], rb_d[i]);
            end
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] exp_v;
        idle_inputs();
        we = 1'b1; waddr = 4'd0; wdata = 32'hFFFFFFFF;
        re = 1'b1; ra_addr = 4'd0; rb_addr = 4'd0;
        for (int pass = 0; pass < 2; pass++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                exp_v = zr(i) ? 32'h0 : 32'hFFFFFFFF;
                checks++;
                if ({ra_d[i], rb_d[i]} !== {exp_v, exp_v}) begin
                    failures++;
                    $display("FAIL zero_reg pass%0d dut%0d got ra=%h rb=%h exp %h",
                             pass, i, ra_d[i], rb_d[i], exp_v);
                end
            end
            we = 1'b0;
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp_v;
        idle_inputs();
        we = 1'b1; waddr = 4'd13; wdata = 32'h13131313;
        re = 1'b1; ra_addr = 4'd13; rb_addr = 4'd13;
        for (int pass = 0; pass < 2; pass++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                exp_v = (dep(i) > 13) ? 32'h13131313 : 32'h0;
                checks++;
                if ({ra_d[i], rb_d[i]} !== {exp_v, exp_v}) begin
                    failures++;
                    $display("FAIL out_of_range pass%0d dut%0d got ra=%h rb=%h exp %h",
                             pass, i, ra_d[i], rb_d[i], exp_v);
                end
            end
            we = 1'b0;
        end
    endtask

    task automatic test_clear();
        int cnt [N];
        idle_inputs();
        for (int a = 0; a < 16; a++) begin
            we = 1'b1; waddr = 4'(a); wdata = $urandom() | 32'h1;
            tick();
        end
        // Edge that starts the sweep still performs its write and read
        we = 1'b1; waddr = 4'd7; wdata = 32'h77770007;
        re = 1'b1; ra_addr = 4'd7; rb_addr = 4'd7; clr_req = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({bsy[i], vld[i], ra_d[i]} !== {1'b1, 1'b1, 32'h77770007}) begin
                failures++;
                $display("FAIL clear_start dut%0d got busy=%b vld=%b ra=%h exp 1 1 77770007",
                         i, bsy[i], vld[i], ra_d[i]);
            end
            cnt[i] = 1;
        end
        for (int n = 1; n < 20; n++) begin
            we = (n <= 10); re = (n <= 10); clr_req = (n <= 8);
            waddr = 4'($urandom_range(0, 15)); wdata = $urandom() | 32'h1;
            ra_addr = 4'($urandom_range(0, 15)); rb_addr = 4'($urandom_range(0, 15));
            tick();
            for (int i = 0; i < N; i++) begin
                if (bsy[i] === 1'b1) cnt[i]++;
                if (n <= 10) begin
                    checks++;
                    if (vld[i] !== 1'b0) begin
                        failures++;
                        $display("FAIL clear_no_read n%0d dut%0d got vld=%b exp 0", n, i, vld[i]);
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (cnt[i] !== dep(i)) begin
                failures++;
                $display("FAIL clear_busy_len dut%0d got %0d cycles exp %0d", i, cnt[i], dep(i));
            end
        end
        idle_inputs();
        for (int a = 0; a < 16; a++) begin
            re = 1'b1; ra_addr = 4'(a); rb_addr = 4'(15 - a);
            tick();
            for (int i = 0; i < N; i++) begin
                checks++;
                if ({vld[i], ra_d[i], rb_d[i]} !== {1'b1, 32'h0, 32'h0}) begin
                    failures++;
                    $display("FAIL clear_readback a%0d dut%0d got vld=%b ra=%h rb=%h exp 1 0 0",
                             a, i, vld[i], ra_d[i], rb_d[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        idle_inputs();
        we = 1'b1; waddr = 4'd2; wdata = 32'h22222222;
        tick();
        we = 1'b0; re = 1'b1; ra_addr = 4'd2; rb_addr = 4'd2;
        tick();
        re = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({bsy[i], vld[i], ra_d[i], rb_d[i]} !== 66'h0) begin
                failures++;
                $display("FAIL reset_mid_sweep dut%0d got busy=%b vld=%b ra=%h rb=%h exp all 0",
                         i, bsy[i], vld[i], ra_d[i], rb_d[i]);
            end
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            re = 1'b1; ra_addr = 4'(a); rb_addr = 4'(a);
            tick();
            for (int i = 0; i < N; i++) begin
                checks++;
                if ({bsy[i], vld[i], ra_d[i], rb_d[i]} !== {1'b0, 1'b1, 32'h0, 32'h0}) begin
                    failures++;
                    $display("FAIL post_reset_read a%0d dut%0d got busy=%b vld=%b ra=%h rb=%h exp 0 1 0 0",
                             a, i, bsy[i], vld[i], ra_d[i], rb_d[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            we      = 1'($urandom_range(0, 1));
            re      = ($urandom_range(0, 3) != 0);
            clr_req = ($urandom_range(0, 39) == 0);
            waddr   = 4'($urandom_range(0, 15));
            wdata   = $urandom();
            ra_addr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            rb_addr = ($urandom_range(0, 3) == 0) ? ra_addr : 4'($urandom_range(0, 15));
            tick();
            for (int i = 0; i < N; i++) begin
                checks++;
                if ({ra_d[i], rb_d[i], vld[i], bsy[i]} !==
                    {m_ra[i], m_rb[i], m_vld[i], (m_left[i] > 0)}) begin
                    failures++;
                    $display("FAIL random n%0d dut%0d got ra=%h rb=%h vld=%b busy=%b exp ra=%h rb=%h vld=%b busy=%b",
                             n, i, ra_d[i], rb_d[i], vld[i], bsy[i],
                             m_ra[i], m_rb[i], m_vld[i], (m_left[i] > 0));
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_out_of_range();
        test_clear();
        test_reset_mid_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
